// File: rtl/regfile_sb.sv
// Two-write-port CPU register file with write-to-read bypass, optional
// hardwired zero register and a per-register busy scoreboard.
module regfile_sb #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          wreg0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          wreg1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic [DW-1:0] ReadData1,
    output logic [DW-1:0] ReadData2,
    input  logic          issue,
    input  logic [AW-1:0] issue_rd,
    output logic          rs_busy,
    output logic          rt_busy,
    output logic [AW:0]   busy_cnt
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    logic [AW-1:0] ra   [2];
    logic [DW-1:0] rdat [2];
    logic          rbsy [2];
    logic          hit0 [2];
    logic          hit1 [2];
    logic          zsel [2];

    // Register array; port 0 wins an address conflict, r0 is read-only when hardwired
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (ZERO_REG == 0 || i != 0) begin
                    if (wreg0 && wa0 == AW'(i)) begin
                        mem[i] <= wd0;
                    end else if (wreg1 && wa1 == AW'(i)) begin
                        mem[i] <= wd1;
                    end
                end
            end
        end
    end

    // Next busy vector: writeback clears, issue sets and overrides a same-cycle clear
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (wreg0 && wa0 == AW'(i)) begin
                busy_nxt[i] = 1'b0;
            end
            if (wreg1 && wa1 == AW'(i)) begin
                busy_nxt[i] = 1'b0;
            end
            if (issue && issue_rd == AW'(i)) begin
                busy_nxt[i] = 1'b1;
            end
            if (ZERO_REG != 0 && i == 0) begin
                busy_nxt[i] = 1'b0;
            end
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    assign ra[0] = rs;
    assign ra[1] = rt;

    // Read ports: zero register, then forwarded write data, then array
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit0[p] = (BYPASS != 0) && wreg0 && (wa0 == ra[p]);
            hit1[p] = (BYPASS != 0) && wreg1 && (wa1 == ra[p]);
            zsel[p] = (ZERO_REG != 0) && (ra[p] == '0);
            rdat[p] = '0;
            rbsy[p] = 1'b0;
            if (RESET && !zsel[p]) begin
                if (hit0[p]) begin
                    rdat[p] = wd0;
                end else if (hit1[p]) begin
                    rdat[p] = wd1;
                end else begin
                    rdat[p] = mem[ra[p]];
                end
                rbsy[p] = busy[ra[p]] && !hit0[p] && !hit1[p];
            end
        end
    end

    assign ReadData1 = rdat[0];
    assign ReadData2 = rdat[1];
    assign rs_busy   = rbsy[0];
    assign rt_busy   = rbsy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (bypass/no zero reg, and zero reg/no
// bypass) driven in lockstep and compared against an array-based model.
module tb_regfile_sb;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          wreg0, wreg1, issue;
    logic [AW-1:0] wa0, wa1, rs, rt, issue_rd;
    logic [DW-1:0] wd0, wd1;

    logic [DW-1:0] rd1 [2];
    logic [DW-1:0] rd2 [2];
    logic          rsb [2];
    logic          rtb [2];
    logic [AW:0]   cnt [2];

    logic [DW-1:0] m_reg  [2][DEPTH];
    bit            m_busy [2][DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(0), .BYPASS(1)) u0 (
        .CLK(CLK), .RESET(RESET),
        .wreg0(wreg0), .wa0(wa0), .wd0(wd0),
        .wreg1(wreg1), .wa1(wa1), .wd1(wd1),
        .rs(rs), .rt(rt), .ReadData1(rd1[0]), .ReadData2(rd2[0]),
        .issue(issue), .issue_rd(issue_rd),
        .rs_busy(rsb[0]), .rt_busy(rtb[0]), .busy_cnt(cnt[0])
    );

    regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(1), .BYPASS(0)) u1 (
        .CLK(CLK), .RESET(RESET),
        .wreg0(wreg0), .wa0(wa0), .wd0(wd0),
        .wreg1(wreg1), .wa1(wa1), .wd1(wd1),
        .rs(rs), .rt(rt), .ReadData1(rd1[1]), .ReadData2(rd2[1]),
        .issue(issue), .issue_rd(issue_rd),
        .rs_busy(rsb[1]), .rt_busy(rtb[1]), .busy_cnt(cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instance 0 has bypass and no zero reg; instance 1 the opposite
    function automatic bit has_zr(input int k);
        return k == 1;
    endfunction

    function automatic bit has_bp(input int k);
        return k == 0;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int k, input logic [AW-1:0] a);
        if (!RESET) return '0;
        if (has_zr(k) && a == 0) return '0;
        if (has_bp(k) && wreg0 && wa0 == a) return wd0;
        if (has_bp(k) && wreg1 && wa1 == a) return wd1;
        return m_reg[k][a];
    endfunction

    function automatic logic exp_bsy(input int k, input logic [AW-1:0] a);
        if (!RESET) return 1'b0;
        if (has_zr(k) && a == 0) return 1'b0;
        if (has_bp(k) && ((wreg0 && wa0 == a) || (wreg1 && wa1 == a))) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic [AW:0] exp_cnt(input int k);
        int s = 0;
        for (int i = 0; i < int'(DEPTH); i++) s += int'(m_busy[k][i]);
        return (AW+1)'(s);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < int'(DEPTH); i++) begin
                m_reg[k][i]  = '0;
                m_busy[k][i] = 1'b0;
            end
    endtask

    task automatic update_model();
        for (int k = 0; k < 2; k++) begin
            if (wreg1 && !(has_zr(k) && wa1 == 0)) m_reg[k][wa1] = wd1;
            if (wreg0 && !(has_zr(k) && wa0 == 0)) m_reg[k][wa0] = wd0;
            if (wreg0) m_busy[k][wa0] = 1'b0;
            if (wreg1) m_busy[k][wa1] = 1'b0;
            if (issue && !(has_zr(k) && issue_rd == 0)) m_busy[k][issue_rd] = 1'b1;
        end
    endtask

    task automatic idle();
        wreg0 = 0; wreg1 = 0; issue = 0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; issue_rd = '0;
    endtask

    // Let inputs settle mid-cycle and compare every output against the model
    task automatic settle();
        if (!RESET) clear_model();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.rd1[%0d]", k, rs), 32'(rd1[k]), 32'(exp_rd(k, rs)));
            chk($sformatf("u%0d.rd2[%0d]", k, rt), 32'(rd2[k]), 32'(exp_rd(k, rt)));
            chk($sformatf("u%0d.rs_busy", k), 32'(rsb[k]), 32'(exp_bsy(k, rs)));
            chk($sformatf("u%0d.rt_busy", k), 32'(rtb[k]), 32'(exp_bsy(k, rt)));
            chk($sformatf("u%0d.busy_cnt", k), 32'(cnt[k]), 32'(exp_cnt(k)));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RESET) update_model();
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b0;
        idle();
        rs = '0; rt = '0;
        clear_model();
        // Writes and issue during reset are ignored
        wreg0 = 1; wa0 = 4'd3; wd0 = 16'h5555; issue = 1; issue_rd = 4'd3; rs = 4'd3;
        settle();
        chk("rst.rd1", 32'(rd1[0]), 32'h0);
        tick();
        idle();
        settle();
        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) begin
            rs = AW'(i); rt = AW'(DEPTH - 1 - i);
            settle(); tick();
        end

        // Basic write then read
        wreg0 = 1; wa0 = 4'd3; wd0 = 16'hA5A5; settle(); tick(); idle();
        rs = 4'd3; settle();
        chk("r3", 32'(rd1[0]), 32'hA5A5);
        chk("r3.nb", 32'(rd1[1]), 32'hA5A5);
        tick();

        // Dual-write conflict, port 0 wins
        wreg0 = 1; wreg1 = 1; wa0 = 4'd5; wa1 = 4'd5; wd0 = 16'h1111; wd1 = 16'h2222;
        settle(); tick(); idle();
        rs = 4'd5; settle();
        chk("r5", 32'(rd1[1]), 32'h1111);
        tick();

        // Dual-write, distinct targets
        wreg0 = 1; wreg1 = 1; wa0 = 4'd6; wa1 = 4'd7; wd0 = 16'h0606; wd1 = 16'h0707;
        settle(); tick(); idle();
        rs = 4'd6; rt = 4'd7; settle();
        chk("r6", 32'(rd1[1]), 32'h0606);
        chk("r7", 32'(rd2[1]), 32'h0707);
        tick();

        // Bypass from port 1, then both ports
        rs = 4'd4; wreg1 = 1; wa1 = 4'd4; wd1 = 16'hBEEF; settle();
        chk("byp1", 32'(rd1[0]), 32'hBEEF);
        chk("nobyp1", 32'(rd1[1]), 32'h0);
        tick();
        wreg0 = 1; wa0 = 4'd4; wd0 = 16'hCAFE; wd1 = 16'hD00D; settle();
        chk("byp0", 32'(rd1[0]), 32'hCAFE);
        chk("nobyp0", 32'(rd1[1]), 32'hBEEF);
        tick(); idle();

        // Scoreboard: issue, writeback, issue+write same cycle
        rs = 4'd9; issue = 1; issue_rd = 4'd9; settle(); tick(); idle();
        settle();
        chk("sb.busy", 32'(rsb[0]), 32'h1);
        chk("sb.cnt", 32'(cnt[0]), 32'h1);
        tick();
        wreg0 = 1; wa0 = 4'd9; wd0 = 16'h0909; settle();
        chk("sb.wb.byp", 32'(rsb[0]), 32'h0);
        chk("sb.wb.nobyp", 32'(rsb[1]), 32'h1);
        tick(); idle();
        settle();
        chk("sb.clr", 32'(cnt[0]), 32'h0);
        tick();
        issue = 1; issue_rd = 4'd9; wreg1 = 1; wa1 = 4'd9; wd1 = 16'h9999;
        settle(); tick(); idle();
        settle();
        chk("sb.setwins", 32'(rsb[0]), 32'h1);
        tick();

        // Zero register
        rs = 4'd0; wreg0 = 1; wa0 = 4'd0; wd0 = 16'hFFFF; issue = 1; issue_rd = 4'd0;
        settle(); tick(); idle();
        settle();
        chk("zr.rd", 32'(rd1[1]), 32'h0);
        chk("zr.busy", 32'(rsb[1]), 32'h0);
        chk("zr.cnt", 32'(cnt[1]), 32'h1);
        tick();

        // Async reset between edges with r2 written and busy
        wreg0 = 1; wa0 = 4'd2; wd0 = 16'h1234; issue = 1; issue_rd = 4'd2; settle(); tick();
        idle(); issue = 1; issue_rd = 4'd2; rs = 4'd2; settle();
        chk("ar.pre", 32'(rd1[0]), 32'h1234);
        tick();
        wreg0 = 1; wa0 = 4'd2; wd0 = 16'h4321; issue = 1; issue_rd = 4'd11; settle();
        #2 RESET = 1'b0;
        settle();
        chk("ar.rd", 32'(rd1[0]), 32'h0);
        chk("ar.cnt", 32'(cnt[0]), 32'h0);
        tick();
        idle(); RESET = 1'b1; settle();
        chk("ar.post", 32'(rd1[0]), 32'h0);
        chk("ar.postb", 32'(rsb[0]), 32'h0);
        tick();

        // Randomized traffic, addresses biased to collide
        for (int n = 0; n < 600; n++) begin
            RESET    = ($urandom_range(0, 79) != 0);
            wreg0    = 1'($urandom);
            wreg1    = 1'($urandom);
            issue    = 1'($urandom);
            wa0      = AW'($urandom_range(0, 7));
            wa1      = AW'($urandom_range(0, 7));
            issue_rd = AW'($urandom_range(0, 7));
            rs       = AW'($urandom_range(0, 7));
            rt       = AW'($urandom);
            wd0      = DW'($urandom);
            wd1      = DW'($urandom);
            settle(); tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised CPU register file with two write ports, write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard. It replaces the single-write-port register file in the CPU datapath. Port 0 serves ALU writeback and port 1 serves load writeback. The scoreboard lets the issue stage detect read-after-write hazards on registers that still have results in flight.

## Interface
- DW, 16, data width in bits
- AW, 4, address width; depth = 2**AW registers
- ZERO_REG, 0, 1 = register 0 always reads 0, discards writes, and is never busy
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports

- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- wreg0  in  1  write enable, port 0 (ALU writeback)
- wa0  in  AW  write address, port 0
- wd0  in  DW  write data, port 0
- wreg1  in  1  write enable, port 1 (load writeback)
- wa1  in  AW  write address, port 1
- wd1  in  DW  write data, port 1
- rs  in  AW  read address 1
- rt  in  AW  read address 2
- ReadData1  out  DW  data of register rs (combinational)
- ReadData2  out  DW  data of register rt (combinational)
- issue  in  1  marks issue_rd as pending at the next edge
- issue_rd  in  AW  destination register of the issued instruction
- rs_busy  out  1  rs has a pending, unresolved write
- rt_busy  out  1  rt has a pending, unresolved write
- busy_cnt  out  AW+1  number of registers currently marked busy

## Operation
- Storage: 2**AW x DW array, plus a busy bit per register.
- Reset, while RESET=0:
  - all registers are 0 and all busy bits are 0;
  - writes and issue are ignored;
  - ReadData1/2 = 0, rs_busy/rt_busy = 0, busy_cnt = 0;
  - bypass is gated off.
- Writes at the rising edge:
  - wregN=1 writes wdN to register waN.
  - If both ports are enabled with wa0==wa1, port 0 wins and port 1's data is dropped. The busy bit is still cleared.
  - If ZERO_REG=1, writes to address 0 are discarded.
- Reads are combinational, with priority per port (ReadData1/rs; ReadData2/rt identical):
  - ZERO_REG=1 and rs==0 → 0;
  - else BYPASS=1, wreg0=1, wa0==rs → wd0;
  - else BYPASS=1, wreg1=1, wa1==rs → wd1;
  - else register[rs].
- Scoreboard, at the rising edge:
  - busy[i] is cleared if either enabled write port targets i;
  - busy[i] is set if issue=1 and issue_rd==i;
  - set and clear on the same register in the same cycle: set wins (a new write is now pending);
  - issue to an already-busy register keeps it busy. There is a single bit, not a count of writers.
- Busy outputs:
  - rs_busy = busy[rs], except it is 0 when ZERO_REG applies to rs;
  - with BYPASS=1, rs_busy is also 0 when an enabled write port targets rs this cycle, because the data is already forwarded;
  - rt_busy is identical on rt.
- busy_cnt:
  - registered population count of the busy bits;
  - updated at the same edge as the bits, so it always equals popcount of the current bits;
  - maximum value 2**AW, or 2**AW-1 when ZERO_REG=1.

## Timing
- Write latency: data written at edge k is visible from the array after edge k. With BYPASS=1 it is visible combinationally in cycle k, before the edge.
- BYPASS=0: a same-cycle read returns the old value and rs_busy stays asserted until after the edge.
- issue at edge k: rs_busy asserts for that register from cycle k+1 onward.
- Writeback in cycle m:
  - BYPASS=1: rs_busy deasserts in cycle m;
  - BYPASS=0: rs_busy deasserts in cycle m+1.
- Reset assertion is asynchronous and takes effect immediately, including mid-write or mid-issue. Deassertion is synchronised externally, and the first write takes effect at the first edge with RESET=1.
- There is no combinational path from issue/issue_rd to any output.

## Test plan
- Reset / basic write-read: after reset, read all addresses → 0 and busy_cnt=0. Write 0xA5A5 to r3 via port 0; next cycle rs=3 → 0xA5A5.
- Dual-write conflict: wreg0=wreg1=1, wa0=wa1=5, wd0=0x1111, wd1=0x2222 → r5=0x1111 afterwards.
- Dual-write, different targets: same cycle, wa0=6 and wa1=7 → both registers updated.
- Bypass, BYPASS=1: rs=4, wreg1=1, wa1=4, wd1=0xBEEF → ReadData1=0xBEEF in the same cycle. With both ports also hitting 4, wd0 is returned.
- Scoreboard: issue r9 at edge k → rs_busy=1 and busy_cnt=1 from cycle k+1. Write r9 in cycle m → rs_busy=0 in cycle m (BYPASS=1) and busy_cnt=0 after edge m. Issue r9 and write r9 in the same cycle → r9 stays busy.
- Zero register (ZERO_REG=1): write 0xFFFF to r0 and issue r0 → r0 reads 0, rs_busy=0, busy_cnt unchanged.
- Async reset mid-operation: drop RESET between edges while r2 holds 0x1234 and is busy → outputs 0 immediately. After RESET rises, r2 reads 0 and is not busy.
